rtc_lectura_bus: RTL and testbench
==================================

Name: rtc_lectura_bus

Overview:
- Upstream feeder of the VGA/text display stage.
- Periodically sweeps a multiplexed address/data RTC chip (V3023-style bus: CS_n, RD_n, WR_n, A_D, 8-bit AD) over nine BCD registers.
- Commits the results atomically as the date/time/timer bytes the display consumes.
- Also generates the alarm level for the display when the countdown timer reaches zero.

Parameters:
- T_PULSE, 8: clk cycles each strobe (WR_n or RD_n) is held low.
- T_GAP, 4: clk cycles of bus idle (all strobes high, CS_n high) after every strobe.
- REFRESH_CYCLES, 5000000: clk cycles waited between sweeps (100 ms at 50 MHz). Minimum 1.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  sweeps start only while high
- alarma_ack  in  1  clears alarma_signal
- ad  inout  8  multiplexed RTC address/data bus
- cs_n  out  1  chip select, active low
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- a_d  out  1  0 = address phase, 1 = data phase
- seg_c, min_c, hora_c  out  8 each  clock seconds/minutes/hours (BCD)
- cambio_dia, cambio_mes, cambio_year  out  8 each  date (BCD)
- seg_t, min_t, hora_t  out  8 each  timer seconds/minutes/hours (BCD)
- alarma_signal  out  1  timer-expired level
- busy  out  1  high while a sweep is in progress
- done_tick  out  1  one-cycle pulse when a sweep commits

Behaviour:
- Reset (reset=0, asynchronous):
  - All nine byte outputs 0x00; alarma_signal, busy and done_tick 0.
  - cs_n, rd_n, wr_n and a_d all 1; ad released (high-Z).
  - idx=0, FSM in IDLE, wait counter 0.
- Register order (idx 0..8): 0x21 seg_c, 0x22 min_c, 0x23 hora_c, 0x24 dia, 0x25 mes, 0x26 year, 0x41 seg_t, 0x42 min_t, 0x43 hora_t.
- FSM states:
  - IDLE: if enable=1, go to ADDR with busy=1 and idx=0.
  - ADDR:
    - cs_n=0, a_d=0, wr_n=0; ad driven with the address for idx.
    - Held for T_PULSE cycles, then go to GAP_A.
    - ad is driven only in ADDR. The driver is released on the same edge wr_n rises.
  - GAP_A: cs_n=1, strobes high, ad high-Z, for T_GAP cycles, then go to DATA.
  - DATA:
    - cs_n=0, a_d=1, rd_n=0; ad high-Z.
    - ad is sampled into shadow[idx] on the final cycle of T_PULSE, the clk edge before rd_n rises.
    - Then go to GAP_D.
  - GAP_D: idle for T_GAP cycles. If idx=8, go to COMMIT; else idx+1 and go to ADDR.
  - COMMIT (1 cycle):
    - All nine outputs load from shadow simultaneously.
    - done_tick=1 for exactly this cycle; busy drops on the next cycle.
    - Then go to WAIT.
  - WAIT: counts REFRESH_CYCLES, then returns to IDLE. IDLE re-samples enable.
- enable deasserted mid-sweep: the sweep completes and commits. No new sweep starts until enable=1.
- Outputs never show a partially updated sweep. The display reads them asynchronously to this FSM.
- Alarm:
  - Evaluated only in COMMIT.
  - If the new {hora_t, min_t, seg_t} = 0 and the previously committed triple ≠ 0, alarma_signal sets on the cycle after COMMIT.
  - alarma_ack=1 clears it. If set and clear fall on the same cycle, set wins.
  - A timer that stays at 0 does not re-assert the alarm.
- Counters: all phase counters are sized from their parameter. Counts wrap to 0 on each state entry.
- Only ADDR drives ad. There is no bus contention in any state, including reset asserted mid-strobe: the driver is released immediately.

Optional Feature:
- Macro: RTC_BCD_CHECK_EN.
- With the macro defined:
  - Each sampled byte is validated in COMMIT. Both nibbles must be ≤9, and the per-register upper limit applies: seconds/minutes ≤0x59, hours ≤0x23, dia 0x01–0x31, mes 0x01–0x12.
  - A failing byte keeps its previous committed value.
  - Extra output bcd_err (1 bit) pulses high in the COMMIT cycle if any byte failed.
- Without the macro: bytes are committed unchecked, and the bcd_err port does not exist.

Test Plan:
- Reset release with enable=1 and an RTC model returning 0x45,0x30,0x12,0x24,0x04,0x16,0x10,0x05,0x00 → first ADDR drives ad=0x21 with wr_n low for 8 cycles. After 9×2×(8+4)+1 cycles, done_tick pulses once and the outputs equal those values.
- Model changes seg_c from 0x45 to 0x46 during the sweep at idx=4 → outputs hold the old 0x45 until COMMIT, then all nine update on the same edge.
- Timer sequence 0x00:00:01 then 0x00:00:00 → alarma_signal rises the cycle after COMMIT. It stays high across the next sweep reading 0 again, and clears on alarma_ack.
- enable dropped at idx=3 → sweep finishes and commits. After WAIT, FSM stays in IDLE with cs_n=1 and busy=0 until enable returns.
- reset pulled low during a DATA strobe → within the same cycle ad is high-Z, all strobes are 1, and outputs are 0x00.
- With RTC_BCD_CHECK_EN, model returns seg_c=0x6A → seg_c keeps its prior value, bcd_err=1 for one cycle, and the other bytes update.

Source files
------------

// File: rtl/rtc_lectura_bus.sv
// Periodic reader of a V3023-style multiplexed RTC bus: sweeps nine BCD registers and
// commits them atomically for the display. Optional byte validation under RTC_BCD_CHECK_EN.
module rtc_lectura_bus #(
  parameter int unsigned T_PULSE        = 8,
  parameter int unsigned T_GAP          = 4,
  parameter int unsigned REFRESH_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       alarma_ack,
  inout  logic [7:0] ad,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] seg_c,
  output logic [7:0] min_c,
  output logic [7:0] hora_c,
  output logic [7:0] cambio_dia,
  output logic [7:0] cambio_mes,
  output logic [7:0] cambio_year,
  output logic [7:0] seg_t,
  output logic [7:0] min_t,
  output logic [7:0] hora_t,
  output logic       alarma_signal,
  output logic       busy,
  output logic       done_tick
`ifdef RTC_BCD_CHECK_EN
  ,
  output logic       bcd_err
`endif
);

  localparam int unsigned PH_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned WT_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(T_PULSE - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(T_GAP - 1);
  localparam logic [WT_W-1:0] WAIT_LAST  = WT_W'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP_A,
    ST_DATA,
    ST_GAP_D,
    ST_COMMIT,
    ST_WAIT
  } state_t;

  state_t          state, state_nx;
  logic [PH_W-1:0] ph_cnt;
  logic [WT_W-1:0] wt_cnt;
  logic [3:0]      idx;
  logic [7:0]      shadow    [9];
  logic [7:0]      committed [9];
  logic            ad_oe;
  logic            load_commit;
  logic            prev_t_nz;

  function automatic logic [7:0] reg_addr(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      default: return 8'h43;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (enable) state_nx = ST_ADDR;
      ST_ADDR:   if (ph_cnt == PULSE_LAST) state_nx = ST_GAP_A;
      ST_GAP_A:  if (ph_cnt == GAP_LAST) state_nx = ST_DATA;
      ST_DATA:   if (ph_cnt == PULSE_LAST) state_nx = ST_GAP_D;
      ST_GAP_D:  if (ph_cnt == GAP_LAST) state_nx = (idx == 4'd8) ? ST_COMMIT : ST_ADDR;
      ST_COMMIT: state_nx = ST_WAIT;
      ST_WAIT:   if (wt_cnt == WAIT_LAST) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Bus strobes are decoded straight from the state so an asynchronous reset
  // releases ad and raises every strobe without waiting for a clock edge.
  always_comb begin
    cs_n      = 1'b1;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    a_d       = 1'b1;
    ad_oe     = 1'b0;
    busy      = 1'b0;
    done_tick = 1'b0;
    case (state)
      ST_ADDR: begin
        cs_n  = 1'b0;
        a_d   = 1'b0;
        wr_n  = 1'b0;
        ad_oe = 1'b1;
        busy  = 1'b1;
      end
      ST_GAP_A: busy = 1'b1;
      ST_DATA: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
        busy = 1'b1;
      end
      ST_GAP_D: busy = 1'b1;
      ST_COMMIT: begin
        busy      = 1'b1;
        done_tick = 1'b1;
      end
      default: ;
    endcase
  end

  assign ad = ad_oe ? reg_addr(idx) : 'z;

  assign load_commit = (state == ST_GAP_D) && (ph_cnt == GAP_LAST) && (idx == 4'd8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_cnt <= '0;
      wt_cnt <= '0;
    end else if (state_nx != state) begin
      ph_cnt <= '0;
      wt_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wt_cnt <= wt_cnt + 1'b1;
    end else if (state inside {ST_ADDR, ST_GAP_A, ST_DATA, ST_GAP_D}) begin
      ph_cnt <= ph_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (state == ST_IDLE && enable) begin
      idx <= '0;
    end else if (state == ST_GAP_D && ph_cnt == GAP_LAST && idx != 4'd8) begin
      idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < 9; k++) shadow[k] <= '0;
    end else if (state == ST_DATA && ph_cnt == PULSE_LAST) begin
      shadow[idx] <= ad;
    end
  end

`ifdef RTC_BCD_CHECK_EN
  function automatic logic bcd_ok(input int unsigned k, input logic [7:0] b);
    logic digits_ok;
    logic range_ok;
    digits_ok = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    case (k)
      0, 1, 6, 7: range_ok = (b <= 8'h59);
      2, 8:       range_ok = (b <= 8'h23);
      3:          range_ok = (b >= 8'h01) && (b <= 8'h31);
      4:          range_ok = (b >= 8'h01) && (b <= 8'h12);
      default:    range_ok = 1'b1;
    endcase
    return digits_ok && range_ok;
  endfunction

  logic [8:0] byte_bad;

  always_comb begin
    byte_bad = '0;
    for (int unsigned k = 0; k < 9; k++) byte_bad[k] = !bcd_ok(k, shadow[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bcd_err <= 1'b0;
    else        bcd_err <= load_commit && (|byte_bad);
  end
`endif

  // Outputs load on the edge entering COMMIT, so done_tick coincides with the new values;
  // prev_t_nz keeps the old timer's state for the alarm decision taken during COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < 9; k++) committed[k] <= '0;
      prev_t_nz <= 1'b0;
    end else if (load_commit) begin
      for (int unsigned k = 0; k < 9; k++) begin
`ifdef RTC_BCD_CHECK_EN
        if (!byte_bad[k]) committed[k] <= shadow[k];
`else
        committed[k] <= shadow[k];
`endif
      end
      prev_t_nz <= |{committed[8], committed[7], committed[6]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarma_signal <= 1'b0;
    end else if (state == ST_COMMIT && prev_t_nz &&
                 {committed[8], committed[7], committed[6]} == 24'h0) begin
      alarma_signal <= 1'b1;
    end else if (alarma_ack) begin
      alarma_signal <= 1'b0;
    end
  end

  assign seg_c       = committed[0];
  assign min_c       = committed[1];
  assign hora_c      = committed[2];
  assign cambio_dia  = committed[3];
  assign cambio_mes  = committed[4];
  assign cambio_year = committed[5];
  assign seg_t       = committed[6];
  assign min_t       = committed[7];
  assign hora_t      = committed[8];

endmodule

// File: tb/tb_rtc_lectura_bus.sv
// Bench for rtc_lectura_bus: RTC bus model, alarm/commit reference model, table vectors,
// hand sequences and randomized sweeps. Honors RTC_BCD_CHECK_EN when defined.
module tb_rtc_lectura_bus;
  localparam int T_P     = 8;
  localparam int T_G     = 4;
  localparam int REFRESH = 20;
  localparam bit BCD_CHK =
`ifdef RTC_BCD_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       alarma_ack = 1'b0;
  wire  [7:0] ad;
  logic       cs_n, rd_n, wr_n, a_d;
  logic [7:0] seg_c, min_c, hora_c, cambio_dia, cambio_mes, cambio_year;
  logic [7:0] seg_t, min_t, hora_t;
  logic       alarma_signal, busy, done_tick;
`ifdef RTC_BCD_CHECK_EN
  logic       bcd_err;
`endif

  rtc_lectura_bus #(.T_PULSE(T_P), .T_GAP(T_G), .REFRESH_CYCLES(REFRESH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .alarma_ack(alarma_ack), .ad(ad),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .seg_c(seg_c), .min_c(min_c), .hora_c(hora_c),
    .cambio_dia(cambio_dia), .cambio_mes(cambio_mes), .cambio_year(cambio_year),
    .seg_t(seg_t), .min_t(min_t), .hora_t(hora_t),
    .alarma_signal(alarma_signal), .busy(busy), .done_tick(done_tick)
`ifdef RTC_BCD_CHECK_EN
    , .bcd_err(bcd_err)
`endif
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RTC chip model: latches the address phase, answers the data phase from mem.
  logic [7:0] mem    [9];
  logic [7:0] rd_log [9];
  logic [7:0] addr_lat = 8'h00;
  logic [7:0] rtc_out;
  logic       probe = 1'b0;
  int         ri;

  function automatic int reg_idx(input logic [7:0] a);
    case (a)
      8'h21: return 0;
      8'h22: return 1;
      8'h23: return 2;
      8'h24: return 3;
      8'h25: return 4;
      8'h26: return 5;
      8'h41: return 6;
      8'h42: return 7;
      8'h43: return 8;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] reg_addr(input int k);
    logic [7:0] hi;
    hi = (k < 6) ? 8'h21 : 8'h41;
    return hi + 8'((k < 6) ? k : k - 6);
  endfunction

  always_comb begin
    ri = reg_idx(addr_lat);
    rtc_out = 8'hEE;
    if (ri >= 0) rtc_out = mem[ri];
  end

  assign ad = (!cs_n && !rd_n && a_d) ? rtc_out : 8'bz;
  assign ad = probe ? 8'h5A : 8'bz;

  function automatic logic [71:0] outs_v();
    return {hora_t, min_t, seg_t, cambio_year, cambio_mes, cambio_dia, hora_c, min_c, seg_c};
  endfunction

  // Bus protocol / atomicity monitor
  int          wr_low = 0, rd_low = 0, seq = 0;
  logic [71:0] last_outs = '0;

  always @(negedge clk) begin
    if (!reset) begin
      wr_low = 0;
      rd_low = 0;
      seq = 0;
      last_outs = outs_v();
    end else begin
      if (!wr_n) begin
        if (wr_low == 0) begin
          check("addr phase", 72'({cs_n, a_d, rd_n, ad}), 72'({1'b0, 1'b0, 1'b1, reg_addr(seq)}));
          seq = (seq + 1) % 9;
        end
        if (!cs_n && !a_d) addr_lat = ad;
        wr_low++;
      end else if (wr_low != 0) begin
        check("wr_n width", 72'(wr_low), 72'(T_P));
        wr_low = 0;
      end
      if (!rd_n) begin
        if (rd_low == 0) check("data phase", 72'({cs_n, a_d, wr_n}), 72'(3'b011));
        if (ri >= 0) rd_log[ri] = rtc_out;
        rd_low++;
      end else if (rd_low != 0) begin
        check("rd_n width", 72'(rd_low), 72'(T_P));
        rd_low = 0;
      end
      if (outs_v() !== last_outs) begin
        check("atomic update on done_tick", 72'(done_tick), 72'd1);
        last_outs = outs_v();
      end
    end
  end

  // Reference model: committed bytes and alarm level
  logic [71:0] exp_out = '0;
  logic        alarm_m = 1'b0;

  function automatic bit byte_ok(input int k, input logic [7:0] b);
    int tens, units, v;
    tens  = int'(b[7:4]);
    units = int'(b[3:0]);
    v     = tens * 10 + units;
    if (!BCD_CHK) return 1'b1;
    if (tens > 9 || units > 9) return 1'b0;
    case (k)
      0, 1, 6, 7: return v <= 59;
      2, 8:       return v <= 23;
      3:          return v >= 1 && v <= 31;
      4:          return v >= 1 && v <= 12;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic compare_commit(input logic [71:0] exp_o, input bit pre, input bit post,
                                input string tag);
    check({tag, " outputs"}, outs_v(), exp_o);
    check({tag, " alarm at commit"}, 72'(alarma_signal), 72'(pre));
    @(negedge clk);
    check({tag, " alarm after commit"}, 72'(alarma_signal), 72'(post));
    check({tag, " done/busy after commit"}, 72'({done_tick, busy}), 72'(2'b00));
    exp_out = exp_o;
    alarm_m = post;
  endtask

  task automatic apply_model(input string tag);
    logic [71:0] e;
    bit          post;
    for (int k = 0; k < 9; k++)
      e[k*8 +: 8] = byte_ok(k, rd_log[k]) ? rd_log[k] : exp_out[k*8 +: 8];
    post = (e[71:48] == 24'h0 && exp_out[71:48] != 24'h0) ? 1'b1 : alarm_m;
    compare_commit(e, alarm_m, post, tag);
  endtask

  task automatic wait_done(input bit mutate, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (done_tick) ok = 1'b1;
      else if (mutate && rd_n && $urandom_range(29) == 0) mem[$urandom_range(8)] = 8'($urandom);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_tick wait: got none expected pulse within 800 cycles");
    end
  endtask

  task automatic wait_addr(input logic [7:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (!wr_n && ad == a) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL address wait: got none expected %h within 800 cycles", a);
    end
  endtask

  task automatic pulse_ack();
    alarma_ack = 1'b1;
    @(negedge clk);
    alarma_ack = 1'b0;
    alarm_m = 1'b0;
  endtask

  task automatic load_mem(input logic [71:0] v);
    for (int k = 0; k < 9; k++) mem[k] = v[k*8 +: 8];
  endtask

  typedef struct packed {
    logic [71:0] vals;
    logic        ack_pulse;
    logic        ack_hold;
    logic        pre;
    logic        post;
  } vec_t;

  vec_t tbl [7];

  initial begin
    bit ok;
    int n, wr_cnt, active;
    logic [71:0] v0;

    // {hora_t,min_t,seg_t,year,mes,dia,hora_c,min_c,seg_c}; flags ack_pulse,ack_hold,pre,post
    v0     = 72'h00_05_10_16_04_24_12_30_45;
    tbl[0] = {72'h00_00_01_16_04_24_12_30_45, 4'b0000};
    tbl[1] = {72'h00_00_00_16_04_25_13_31_46, 4'b0001};
    tbl[2] = {72'h00_00_00_16_04_24_12_30_45, 4'b0011};
    tbl[3] = {72'h00_00_00_17_05_01_00_00_00, 4'b1000};
    tbl[4] = {72'h00_01_00_16_04_24_12_30_45, 4'b0000};
    tbl[5] = {72'h00_00_00_99_12_31_23_59_59, 4'b0101};
    tbl[6] = {72'h23_59_59_00_01_01_00_00_07, 4'b1000};

    load_mem(v0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("reset strobes", 72'({cs_n, rd_n, wr_n, a_d}), 72'(4'hF));
    check("reset outputs", outs_v(), 72'h0);
    check("reset flags", 72'({alarma_signal, busy, done_tick}), 72'(3'b000));
    probe = 1'b1;
    #1 check("reset ad released", 72'(ad), 72'h5A);
    probe = 1'b0;

    // First sweep: address timing and commit latency
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    wr_cnt = 0;
    ok = 1'b0;
    for (int i = 1; i <= 600 && !ok; i++) begin
      @(negedge clk);
      if (i == 1) check("first addr", 72'({wr_n, ad}), 72'({1'b0, 8'h21}));
      if (i <= 12 && !wr_n) wr_cnt++;
      if (done_tick) begin
        ok = 1'b1;
        n = i;
      end
    end
    check("first wr_n low cycles", 72'(wr_cnt), 72'(T_P));
    check("commit latency", 72'(n), 72'(9 * 2 * (T_P + T_G) + 1));
    if (ok) compare_commit(v0, 1'b0, 1'b0, "sweep0");

    // Table-driven alarm / commit vectors
    for (int t = 0; t < 7; t++) begin
      load_mem(tbl[t].vals);
      if (tbl[t].ack_pulse) pulse_ack();
      if (tbl[t].ack_hold) alarma_ack = 1'b1;
      wait_done(1'b0, ok);
      if (ok) compare_commit(tbl[t].vals, tbl[t].pre, tbl[t].post, $sformatf("vec%0d", t));
      alarma_ack = 1'b0;
    end

    // seg_c changes after it was read: outputs hold until the commit edge
    load_mem(v0);
    wait_addr(8'h25, ok);
    mem[0] = 8'h46;
    check("hold before commit", 72'(seg_c), 72'h07);
    wait_done(1'b0, ok);
    check("seg_c read before change", 72'(seg_c), 72'h45);
    if (ok) apply_model("midsweep");

    // enable dropped mid-sweep: sweep completes, then the block idles
    wait_addr(8'h24, ok);
    enable = 1'b0;
    wait_done(1'b0, ok);
    if (ok) apply_model("enable drop");
    active = 0;
    repeat (REFRESH + 40) begin
      @(negedge clk);
      if (!cs_n || busy || done_tick) active++;
    end
    check("idle while disabled", 72'(active), 72'h0);
    enable = 1'b1;
    wait_done(1'b0, ok);
    if (ok) apply_model("enable return");

`ifdef RTC_BCD_CHECK_EN
    mem[0] = 8'h6A;
    wait_done(1'b0, ok);
    check("bcd_err at commit", 72'(bcd_err), 72'd1);
    check("invalid seg_c kept", 72'(seg_c), 72'(exp_out[7:0]));
    if (ok) apply_model("bcd check");
    check("bcd_err one cycle", 72'(bcd_err), 72'd0);
    mem[0] = 8'h33;
`endif

    // Reset asserted during a DATA strobe
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (!rd_n) ok = 1'b1;
    end
    check("reached data strobe", 72'(ok), 72'd1);
    reset = 1'b0;
    #1;
    check("midstrobe reset strobes", 72'({cs_n, rd_n, wr_n, a_d}), 72'(4'hF));
    check("midstrobe reset outputs", outs_v(), 72'h0);
    check("midstrobe reset flags", 72'({alarma_signal, busy, done_tick}), 72'(3'b000));
    probe = 1'b1;
    #1 check("midstrobe ad released", 72'(ad), 72'h5A);
    probe = 1'b0;
    repeat (3) @(negedge clk);
    exp_out = '0;
    alarm_m = 1'b0;
    reset = 1'b1;
    wait_done(1'b0, ok);
    if (ok) apply_model("after reset");

    // Randomized sweeps with bytes changing while the sweep runs
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 9; k++) mem[k] = 8'($urandom);
      if ($urandom_range(2) == 0) begin
        mem[6] = 8'h00;
        mem[7] = 8'h00;
        mem[8] = 8'h00;
      end
      if ($urandom_range(3) == 0) pulse_ack();
      wait_done(1'b1, ok);
      if (ok) apply_model($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
